// File: rtl/emesh_axi_master_read_if.sv
// Local read request, AXI AR/R channels and local beat
// delivery bundled between the read master and its peers.
interface emesh_axi_master_read_if #(
    parameter int IDW = 12,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic [7:0]     req_len;
    logic [2:0]     req_size;
    logic [1:0]     req_burst;
    logic [IDW-1:0] req_id;

    logic           m_axi_arvalid;
    logic           m_axi_arready;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic [IDW-1:0] m_axi_arid;
    logic [3:0]     m_axi_arcache;
    logic [2:0]     m_axi_arprot;
    logic           m_axi_arlock;
    logic [3:0]     m_axi_arqos;

    logic           m_axi_rvalid;
    logic           m_axi_rready;
    logic [DW-1:0]  m_axi_rdata;
    logic [1:0]     m_axi_rresp;
    logic           m_axi_rlast;
    logic [IDW-1:0] m_axi_rid;

    logic           rd_valid;
    logic           rd_ready;
    logic [DW-1:0]  rd_data;
    logic [1:0]     rd_resp;
    logic           rd_last;

    logic           busy;
    logic           done;
    logic [2:0]     err;

    modport master (
        input  req_valid, req_addr, req_len, req_size, req_burst, req_id,
        output req_ready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        output m_axi_arburst, m_axi_arid, m_axi_arcache, m_axi_arprot,
        output m_axi_arlock, m_axi_arqos,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
        output m_axi_rready,
        output rd_valid, rd_data, rd_resp, rd_last,
        input  rd_ready,
        output busy, done, err
    );

    modport slave (
        output req_valid, req_addr, req_len, req_size, req_burst, req_id,
        input  req_ready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        input  m_axi_arburst, m_axi_arid, m_axi_arcache, m_axi_arprot,
        input  m_axi_arlock, m_axi_arqos,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
        input  m_axi_rready,
        input  rd_valid, rd_data, rd_resp, rd_last,
        output rd_ready,
        input  busy, done, err
    );
endinterface

// File: rtl/emesh_axi_master_read.sv
// Single-outstanding AXI read master: issues one AR, then
// forwards R beats through a one-entry skid register.
module emesh_axi_master_read #(
    parameter int IDW = 12,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input logic clk,
    input logic rst,
    emesh_axi_master_read_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t         state;
    logic [7:0]     beat_rem;
    logic           arvalid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic [IDW-1:0] arid;
    logic           rd_valid;
    logic [DW-1:0]  rd_data;
    logic [1:0]     rd_resp;
    logic           rd_last;
    logic           done;
    logic [2:0]     err;

    logic req_hs;
    logic r_hs;
    logic d_hs;
    logic rready;
    logic len_bad;

    assign req_hs  = bus.req_valid && (state == IDLE);
    assign rready  = (state == DATA) && (!rd_valid || bus.rd_ready);
    assign r_hs    = bus.m_axi_rvalid && rready;
    assign d_hs    = rd_valid && bus.rd_ready;
    assign len_bad = bus.m_axi_rlast ? (beat_rem != 8'd0) : (beat_rem == 8'd0);

    assign bus.req_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_araddr  = araddr;
    assign bus.m_axi_arlen   = arlen;
    assign bus.m_axi_arsize  = arsize;
    assign bus.m_axi_arburst = arburst;
    assign bus.m_axi_arid    = arid;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arqos   = 4'b0000;
    assign bus.m_axi_rready  = rready;
    assign bus.rd_valid      = rd_valid;
    assign bus.rd_data       = rd_data;
    assign bus.rd_resp       = rd_resp;
    assign bus.rd_last       = rd_last;
    assign bus.done          = done;
    assign bus.err           = err;

    // Transaction FSM: AR issue, beat counting, sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_rem <= '0;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
            arburst  <= '0;
            arid     <= '0;
            done     <= 1'b0;
            err      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_hs) begin
                        araddr   <= bus.req_addr;
                        arlen    <= bus.req_len;
                        arsize   <= bus.req_size;
                        arburst  <= bus.req_burst;
                        arid     <= bus.req_id;
                        beat_rem <= bus.req_len;
                        err      <= '0;
                        arvalid  <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_axi_arready) begin
                        arvalid <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_rem <= beat_rem - 8'd1;
                        err[0]   <= err[0] | bus.m_axi_rresp[1];
                        err[1]   <= err[1] | (bus.m_axi_rid != arid);
                        err[2]   <= err[2] | len_bad;
                        if (bus.m_axi_rlast) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output beat register: refill on R handshake, empty on local drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_resp  <= '0;
            rd_last  <= 1'b0;
        end else if (r_hs) begin
            rd_valid <= 1'b1;
            rd_data  <= bus.m_axi_rdata;
            rd_resp  <= bus.m_axi_rresp;
            rd_last  <= bus.m_axi_rlast;
        end else if (d_hs) begin
            rd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_emesh_axi_master_read.sv
// Bench for emesh_axi_master_read: vector table of read
// transactions, scoreboarded beats, reset corner cases.
module tb_emesh_axi_master_read;
    localparam int IDW = 12;
    localparam int AW  = 32;
    localparam int DW  = 32;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        logic [IDW-1:0] id;
        int             ar_delay;
        logic [DW-1:0]  dbase;
        int             bad_beat;
        logic [1:0]     bad_resp;
        logic [IDW-1:0] bad_id;
        int             last_beat;
        int             mode;
        logic [2:0]     exp_err;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    beat_t q[$];
    vec_t vecs[8];

    emesh_axi_master_read_if #(.IDW(IDW), .AW(AW), .DW(DW)) bus ();

    emesh_axi_master_read #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 64'd0);
        chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        chk({tag, "_rd_last"}, 64'(bus.rd_last), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
        chk({tag, "_rd_resp"}, 64'(bus.rd_resp), 64'd0);
        chk({tag, "_araddr"}, 64'(bus.m_axi_araddr), 64'd0);
        chk({tag, "_arlen"}, 64'(bus.m_axi_arlen), 64'd0);
        chk({tag, "_arid"}, 64'(bus.m_axi_arid), 64'd0);
        chk({tag, "_rready"}, 64'(bus.m_axi_rready), 64'd0);
    endtask

    task automatic do_req(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_len   = v.len;
        bus.req_size  = v.size;
        bus.req_burst = v.burst;
        bus.req_id    = v.id;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = '1;
        bus.req_len   = '1;
        bus.req_id    = '1;
        chk("arvalid_latency", 64'(bus.m_axi_arvalid), 64'd1);
        chk("araddr", 64'(bus.m_axi_araddr), 64'(v.addr));
        chk("arlen", 64'(bus.m_axi_arlen), 64'(v.len));
        chk("arsize", 64'(bus.m_axi_arsize), 64'(v.size));
        chk("arburst", 64'(bus.m_axi_arburst), 64'(v.burst));
        chk("arid", 64'(bus.m_axi_arid), 64'(v.id));
        chk("arcache", 64'(bus.m_axi_arcache), 64'h3);
        chk("arprot_lock_qos",
            64'({bus.m_axi_arprot, bus.m_axi_arlock, bus.m_axi_arqos}), 64'd0);
        chk("busy_addr", 64'(bus.busy), 64'd1);
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        chk("err_cleared", 64'(bus.err), 64'd0);
        chk("rready_addr", 64'(bus.m_axi_rready), 64'd0);
    endtask

    task automatic do_ar(input vec_t v);
        for (int i = 0; i < v.ar_delay; i++) begin
            @(negedge clk);
            chk("arvalid_hold", 64'(bus.m_axi_arvalid), 64'd1);
            chk("araddr_stable", 64'(bus.m_axi_araddr), 64'(v.addr));
            chk("arid_stable", 64'(bus.m_axi_arid), 64'(v.id));
            chk("rready_wait_ar", 64'(bus.m_axi_rready), 64'd0);
        end
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        bus.m_axi_arready = 1'b0;
        chk("arvalid_drop", 64'(bus.m_axi_arvalid), 64'd0);
        chk("busy_data", 64'(bus.busy), 64'd1);
    endtask

    task automatic do_data(input vec_t v);
        int b = 0;
        int nb = v.last_beat + 1;
        int post = 0;
        int dones = 0;
        int cyc = 0;
        logic hold = 1'b0;
        logic [DW-1:0] prev = '0;
        beat_t e;
        while ((b < nb || q.size() > 0 || post < 2) && cyc < 300) begin
            case (v.mode)
                0: bus.rd_ready = 1'b1;
                1: bus.rd_ready = (cyc % 2) == 0;
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (b < nb) begin
                bus.m_axi_rvalid = 1'b1;
                bus.m_axi_rdata  = v.dbase + DW'(b);
                bus.m_axi_rlast  = (b == v.last_beat);
                bus.m_axi_rresp  = (b == v.bad_beat) ? v.bad_resp : {1'b0, 1'(b)};
                bus.m_axi_rid    = (b == v.bad_beat) ? v.bad_id : v.id;
            end else begin
                bus.m_axi_rvalid = 1'b0;
            end
            #1;
            if (bus.done) begin
                dones++;
                chk("req_ready_at_done", 64'(bus.req_ready), 64'd1);
            end
            if (bus.rd_valid && !bus.rd_ready)
                chk("rready_backpressure", 64'(bus.m_axi_rready), 64'd0);
            if (hold)
                chk("rd_data_hold", 64'(bus.rd_data), 64'(prev));
            hold = bus.rd_valid && !bus.rd_ready;
            prev = bus.rd_data;
            if (bus.rd_valid && bus.rd_ready) begin
                if (q.size() == 0) begin
                    chk("beat_unexpected", 64'(bus.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", 64'(bus.rd_data), 64'(e.data));
                    chk("rd_resp", 64'(bus.rd_resp), 64'(e.resp));
                    chk("rd_last", 64'(bus.rd_last), 64'(e.last));
                end
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                q.push_back('{bus.m_axi_rdata, bus.m_axi_rresp, bus.m_axi_rlast});
                b++;
            end
            if (b >= nb) post++;
            cyc++;
            @(negedge clk);
        end
        bus.m_axi_rvalid = 1'b0;
        bus.rd_ready = 1'b1;
        chk("data_timeout", 64'(cyc < 300), 64'd1);
        chk("beats_lost", 64'(q.size()), 64'd0);
        q.delete();
        chk("done_pulses", 64'(dones), 64'd1);
        chk("err_final", 64'(bus.err), 64'(v.exp_err));
        chk("busy_end", 64'(bus.busy), 64'd0);
        chk("rd_valid_end", 64'(bus.rd_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        do_req(v);
        do_ar(v);
        do_data(v);
    endtask

    initial begin
        vec_t r;
        vecs[0] = '{32'h1000, 8'd0, 3'd2, 2'd1, 12'h5A5, 3, 32'hDEADBEEF,
                    -1, 2'b00, 12'h000, 0, 0, 3'b000};
        vecs[1] = '{32'h2000_0040, 8'd3, 3'd2, 2'd1, 12'h011, 1, 32'h1000_0000,
                    -1, 2'b00, 12'h000, 3, 1, 3'b000};
        vecs[2] = '{32'h3000, 8'd3, 3'd2, 2'd1, 12'h123, 0, 32'hA0A0_0000,
                    1, 2'b10, 12'h001, 3, 0, 3'b011};
        vecs[3] = '{32'h4000, 8'd3, 3'd2, 2'd1, 12'h222, 2, 32'hB000_0000,
                    -1, 2'b00, 12'h000, 1, 0, 3'b100};
        vecs[4] = '{32'h5004, 8'd0, 3'd3, 2'd0, 12'hFFF, 0, 32'hC000_0000,
                    0, 2'b11, 12'hFFF, 0, 2, 3'b001};
        vecs[5] = '{32'h6000, 8'd7, 3'd2, 2'd2, 12'h333, 1, 32'hD000_0000,
                    -1, 2'b00, 12'h000, 7, 2, 3'b000};
        vecs[6] = '{32'h7000, 8'd1, 3'd1, 2'd1, 12'h444, 0, 32'hE000_0000,
                    -1, 2'b00, 12'h000, 2, 1, 3'b100};
        vecs[7] = '{32'h8000, 8'd2, 3'd2, 2'd1, 12'h800, 1, 32'hF000_0000,
                    2, 2'b01, 12'h000, 2, 0, 3'b010};

        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_len = '0;
        bus.req_size = '0;
        bus.req_burst = '0;
        bus.req_id = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0;
        bus.m_axi_rresp = '0;
        bus.m_axi_rlast = 1'b0;
        bus.m_axi_rid = '0;
        bus.rd_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        #1;
        chk("req_ready_after_por", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        r = '{32'h9000, 8'd7, 3'd2, 2'd1, 12'h0AB, 0, 32'h5555_0000,
              -1, 2'b00, 12'h000, 7, 0, 3'b000};
        do_req(r);
        do_ar(r);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 32'h1234_5678;
        bus.m_axi_rresp  = 2'b10;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rid    = 12'h0AB;
        bus.rd_ready     = 1'b0;
        #1;
        chk("rst_seq_rready", 64'(bus.m_axi_rready), 64'd1);
        @(negedge clk);
        bus.m_axi_rvalid = 1'b0;
        chk("rst_seq_beat1_valid", 64'(bus.rd_valid), 64'd1);
        chk("rst_seq_beat1_data", 64'(bus.rd_data), 64'h1234_5678);
        chk("rst_seq_err_pre", 64'(bus.err), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        chk("midrst_no_done", 64'(bus.done), 64'd0);
        chk("midrst_rready", 64'(bus.m_axi_rready), 64'd0);
        rst = 1'b0;
        bus.rd_ready = 1'b1;
        #1;
        chk("req_ready_after_midrst", 64'(bus.req_ready), 64'd1);

        for (int i = 4; i < 8; i++) run_vec(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
